ram_scan_reader: RTL

//  Read-side engine for the 32x4 on-board RAM. Steps a read address through every word on a

---
 rtl/ram_scan_reader.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/ram_scan_reader.sv
// ram_scan_reader
//   Read-side engine for a small dual-port RAM. It walks the read address
//   through every word and issues a synchronous read for each one. It then
//   presents each captured address/data pair to the display logic. The
//   engine also watches the write port, so the word on the display always
//   matches what is stored in the RAM.
//
// Parameters
//   ADDR_WIDTH   RAM address width; the scan covers 0 .. 2**ADDR_WIDTH-1
//   DATA_WIDTH   RAM word width
//   TICK_CYCLES  cycles each word is held while enable_i=1 (must be >= 1)
//   RD_LATENCY   cycles from rd_addr_o to rd_data_i; legal values 1 or 2
//
// Ports
//   clk_i         system clock
//   reset_i       synchronous, active-high reset
//   enable_i      1 = auto-advance on tick, 0 = freeze the tick counter
//   step_i        one-cycle pulse: advance to the next word now (HOLD only)
//   rd_addr_o     RAM read address (always the registered scan address)
//   rd_data_i     RAM read data, valid RD_LATENCY cycles after rd_addr_o
//   wr_en_i       snooped RAM write enable
//   wr_addr_i     snooped RAM write address
//   wr_data_i     snooped RAM write data
//   disp_addr_o   address of the displayed word
//   disp_data_o   displayed word
//   disp_valid_o  1 once the first word has been captured
//   wrapped_o     one-cycle pulse after the scan address wraps max -> 0
module ram_scan_reader #(
    parameter int ADDR_WIDTH  = 5,
    parameter int DATA_WIDTH  = 4,
    parameter int TICK_CYCLES = 50_000_000,
    parameter int RD_LATENCY  = 1
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  enable_i,
    input  logic                  step_i,
    output logic [ADDR_WIDTH-1:0] rd_addr_o,
    input  logic [DATA_WIDTH-1:0] rd_data_i,
    input  logic                  wr_en_i,
    input  logic [ADDR_WIDTH-1:0] wr_addr_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    output logic [ADDR_WIDTH-1:0] disp_addr_o,
    output logic [DATA_WIDTH-1:0] disp_data_o,
    output logic                  disp_valid_o,
    output logic                  wrapped_o
);

    localparam logic [1:0] ST_ISSUE = 2'd0;
    localparam logic [1:0] ST_WAIT  = 2'd1;
    localparam logic [1:0] ST_HOLD  = 2'd2;

    localparam int                    TICK_W    = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [TICK_W-1:0]     TICK_LAST = TICK_W'(TICK_CYCLES - 1);
    localparam logic [1:0]            LAT_LAST  = 2'(RD_LATENCY - 1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_MAX  = '1;

    logic [1:0]            state_q, state_d;
    logic [1:0]            lat_cnt_q, lat_cnt_d;
    logic [TICK_W-1:0]     tick_cnt_q, tick_cnt_d;
    logic [ADDR_WIDTH-1:0] scan_addr_q, scan_addr_d;
    logic [ADDR_WIDTH-1:0] disp_addr_q, disp_addr_d;
    logic [DATA_WIDTH-1:0] disp_data_q, disp_data_d;
    logic                  disp_valid_q, disp_valid_d;
    logic                  wrapped_q, wrapped_d;
    // pend_*: the newest write to the word being fetched. The RAM returns
    // the contents from before that write, so this value takes precedence.
    logic                  pend_valid_q, pend_valid_d;
    logic [DATA_WIDTH-1:0] pend_data_q, pend_data_d;

    logic scan_hit;
    logic advance;

    assign scan_hit = wr_en_i && (wr_addr_i == scan_addr_q);

    always_comb begin
        // NOTE: every next-state signal defaults to its register first, so no path through the case infers a latch.
        state_d      = state_q;
        lat_cnt_d    = lat_cnt_q;
        tick_cnt_d   = tick_cnt_q;
        scan_addr_d  = scan_addr_q;
        disp_addr_d  = disp_addr_q;
        disp_data_d  = disp_data_q;
        disp_valid_d = disp_valid_q;
        wrapped_d    = 1'b0;
        pend_valid_d = pend_valid_q;
        pend_data_d  = pend_data_q;
        advance      = 1'b0;

        case (state_q)
            ST_ISSUE: begin
                lat_cnt_d    = '0;
                // A new fetch starts with no pending write, except for a write that lands now.
                pend_valid_d = scan_hit;
                if (scan_hit) begin
                    pend_data_d = wr_data_i;
                end
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (lat_cnt_q == LAT_LAST) begin
                    // Capture priority: a write in this cycle, then a pending write, then the RAM.
                    disp_addr_d  = scan_addr_q;
                    disp_data_d  = scan_hit     ? wr_data_i   :
                                   pend_valid_q ? pend_data_q : rd_data_i;
                    disp_valid_d = 1'b1;
                    tick_cnt_d   = '0;
                    state_d      = ST_HOLD;
                end else begin
                    lat_cnt_d = lat_cnt_q + 2'd1;
                    if (scan_hit) begin
                        pend_valid_d = 1'b1;
                        pend_data_d  = wr_data_i;
                    end
                end
            end
            ST_HOLD: begin
                if (wr_en_i && (wr_addr_i == disp_addr_q)) begin
                    disp_data_d = wr_data_i;
                end
                // step_i takes priority and ignores enable_i.
                if (step_i || (enable_i && (tick_cnt_q == TICK_LAST))) begin
                    advance = 1'b1;
                end else if (enable_i) begin
                    tick_cnt_d = tick_cnt_q + TICK_W'(1);
                end
            end
            default: begin
                state_d = ST_ISSUE;
            end
        endcase

        if (advance) begin
            scan_addr_d = scan_addr_q + ADDR_WIDTH'(1);
            wrapped_d   = (scan_addr_q == ADDR_MAX);
            tick_cnt_d  = '0;
            state_d     = ST_ISSUE;
        end
    end

    always_ff @(posedge clk_i) begin
        // NOTE: non-blocking assignments, so every register loads from the values present before the edge.
        if (reset_i) begin
            state_q      <= ST_ISSUE;
            lat_cnt_q    <= '0;
            tick_cnt_q   <= '0;
            scan_addr_q  <= '0;
            disp_addr_q  <= '0;
            disp_data_q  <= '0;
            disp_valid_q <= 1'b0;
            wrapped_q    <= 1'b0;
            pend_valid_q <= 1'b0;
            pend_data_q  <= '0;
        end else begin
            state_q      <= state_d;
            lat_cnt_q    <= lat_cnt_d;
            tick_cnt_q   <= tick_cnt_d;
            scan_addr_q  <= scan_addr_d;
            disp_addr_q  <= disp_addr_d;
            disp_data_q  <= disp_data_d;
            disp_valid_q <= disp_valid_d;
            wrapped_q    <= wrapped_d;
            pend_valid_q <= pend_valid_d;
            pend_data_q  <= pend_data_d;
        end
    end

    assign rd_addr_o    = scan_addr_q;
    assign disp_addr_o  = disp_addr_q;
    assign disp_data_o  = disp_data_q;
    assign disp_valid_o = disp_valid_q;
    assign wrapped_o    = wrapped_q;

endmodule
